// File: rtl/cfg_chain_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader_if
//   Host/flash byte port feeding the configuration chain loader.
//
//   Handshake: a byte moves from host to loader on a rising CLK edge where
//   DIN_VALID and DIN_READY are both high. DIN_VALID while DIN_READY is low
//   is ignored. DIN only has to be valid in the transfer cycle itself.
//   DIN_READY is combinational from loader state and never depends on
//   DIN_VALID, so the host may wait for READY before raising VALID.
//
//   Signals
//     DIN        host -> loader  8  config byte, bit 0 shifted first
//     DIN_VALID  host -> loader  1  DIN carries a byte
//     DIN_READY  loader -> host  1  loader accepts DIN this cycle
//
//   Modports
//     master : host side (drives DIN / DIN_VALID)
//     slave  : loader side (drives DIN_READY)
// ---------------------------------------------------------------------------
interface cfg_chain_loader_if;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;

  modport master (
    output DIN,
    output DIN_VALID,
    input  DIN_READY
  );

  modport slave (
    input  DIN,
    input  DIN_VALID,
    output DIN_READY
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// cfg_chain_loader
//   Sequences fabric configuration. After START it takes bytes from the host
//   port, requires the first one to be SYNC_BYTE, then serialises exactly
//   CHAIN_LEN bits (LSB of each byte first) into the tile config chain. It
//   then pulses CFG_LATCH for LATCH_CYCLES cycles and releases FABRIC_RST.
//   Bits of the final byte beyond CHAIN_LEN are never shifted.
//
//   Parameters
//     CHAIN_LEN     total config bits in the chain (>= 1)
//     SYNC_BYTE     required first byte of every load
//     LATCH_CYCLES  cycles CFG_LATCH stays high (>= 1)
//
//   Ports
//     CLK         in   clock
//     RST         in   synchronous reset, active-high
//     START       in   single-cycle load request (IDLE/DONE/ERROR only)
//     host        if   byte port (slave modport), see cfg_chain_loader_if
//     CFG_DO      out  serial data into the chain head
//     CFG_SHIFT   out  chain captures CFG_DO on this CLK edge
//     CFG_LATCH   out  chain shadow -> active configuration
//     FABRIC_RST  out  high holds the user fabric in reset
//     BUSY        out  load in progress (SYNC/SHIFT/LATCH)
//     DONE        out  configuration active, fabric released
//     ERR         out  sticky sync error (cleared by a new START)
//     STATE_DBG   out  current FSM state code, for observation only
//
//   All outputs are registered except host.DIN_READY.
// ---------------------------------------------------------------------------
module cfg_chain_loader #(
  parameter int unsigned CHAIN_LEN    = 64,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  cfg_chain_loader_if.slave   host,
  output logic                CFG_DO,
  output logic                CFG_SHIFT,
  output logic                CFG_LATCH,
  output logic                FABRIC_RST,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [2:0]          STATE_DBG
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]       state;
  logic [7:0]       shift_buf;  // shift_buf[0] is the bit on CFG_DO
  logic [3:0]       buf_left;   // unshifted bits held in shift_buf, 0..8
  logic [CNT_W-1:0] bit_cnt;    // bits already clocked into the chain
  logic [LAT_W-1:0] latch_cnt;

  logic shifting;
  logic din_ready;
  logic din_xfer;

  assign STATE_DBG = state;

  // -------------------------------------------------------------------------
  // Byte acceptance
  //   In SHIFT a new byte is taken when the buffer is empty, or when its
  //   last bit leaves on this edge, so consecutive bytes stream at one bit
  //   per cycle without a bubble.
  // -------------------------------------------------------------------------
  always_comb begin
    shifting  = (state == S_SHIFT) && (buf_left != 4'd0);
    din_ready = 1'b0;
    if (state == S_SYNC) begin
      din_ready = 1'b1;
    end else if (state == S_SHIFT) begin
      din_ready = (buf_left == 4'd0) || ((buf_left == 4'd1) && shifting);
    end
    din_xfer = host.DIN_VALID && din_ready;
  end

  assign host.DIN_READY = din_ready;

  // -------------------------------------------------------------------------
  // FSM and registered outputs
  //   CFG_SHIFT/CFG_DO are loaded with the values for the coming cycle, so
  //   CFG_SHIFT is high exactly while buf_left is non-zero in SHIFT and
  //   CFG_DO always equals shift_buf[0] while it is.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      shift_buf  <= 8'd0;
      buf_left   <= 4'd0;
      bit_cnt    <= '0;
      latch_cnt  <= '0;
      CFG_DO     <= 1'b0;
      CFG_SHIFT  <= 1'b0;
      CFG_LATCH  <= 1'b0;
      FABRIC_RST <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_SYNC;
            BUSY  <= 1'b1;
          end
        end

        S_SYNC: begin
          if (din_xfer) begin
            if (host.DIN == SYNC_BYTE) begin
              state    <= S_SHIFT;
              bit_cnt  <= '0;
              buf_left <= 4'd0;
            end else begin
              state <= S_ERROR;
              BUSY  <= 1'b0;
              ERR   <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (shifting && (bit_cnt == LAST_BIT)) begin
            // Final chain bit goes out on this edge; whatever is left in
            // the buffer (and any byte taken this cycle) is discarded.
            bit_cnt   <= bit_cnt + CNT_ONE;
            buf_left  <= 4'd0;
            CFG_SHIFT <= 1'b0;
            CFG_DO    <= 1'b0;
            CFG_LATCH <= 1'b1;
            latch_cnt <= '0;
            state     <= S_LATCH;
          end else begin
            if (shifting) begin
              bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (din_xfer) begin
              // Buffer is empty or drains on this edge: refill it.
              shift_buf <= host.DIN;
              buf_left  <= 4'd8;
              CFG_SHIFT <= 1'b1;
              CFG_DO    <= host.DIN[0];
            end else if (buf_left > 4'd1) begin
              shift_buf <= {1'b0, shift_buf[7:1]};
              buf_left  <= buf_left - 4'd1;
              CFG_SHIFT <= 1'b1;
              CFG_DO    <= shift_buf[1];
            end else begin
              // Buffer empties (or stays empty): chain holds.
              buf_left  <= 4'd0;
              CFG_SHIFT <= 1'b0;
              CFG_DO    <= 1'b0;
            end
          end
        end

        S_LATCH: begin
          if (latch_cnt == LAT_LAST) begin
            state      <= S_DONE;
            CFG_LATCH  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            FABRIC_RST <= 1'b0;
          end else begin
            latch_cnt <= latch_cnt + LAT_ONE;
          end
        end

        S_DONE, S_ERROR: begin
          if (START) begin
            state      <= S_SYNC;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            FABRIC_RST <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_chain_loader
//   Self-checking bench for cfg_chain_loader. Main instance: CHAIN_LEN=12,
//   LATCH_CYCLES=2. Second instance: CHAIN_LEN=16, LATCH_CYCLES=3, used for
//   the back-to-back streaming case.
//   Expected chain bits come from the byte list (bit i = byte[i/8] bit i%8,
//   first CHAIN_LEN bits only); monitors pop them on every CFG_SHIFT cycle.
// ---------------------------------------------------------------------------
module tb_cfg_chain_loader;

  localparam int CL   = 12;
  localparam int LC   = 2;
  localparam int CL16 = 16;
  localparam int LC16 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, start16;

  cfg_chain_loader_if bus ();
  cfg_chain_loader_if bus16 ();

  logic       cfg_do, cfg_shift, cfg_latch, fabric_rst, busy, done, err;
  logic [2:0] state_dbg;
  logic       cfg_do16, cfg_shift16, cfg_latch16, fabric_rst16, busy16, done16, err16;
  logic [2:0] state_dbg16;

  cfg_chain_loader #(.CHAIN_LEN(CL), .SYNC_BYTE(8'hA5), .LATCH_CYCLES(LC)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .host(bus),
    .CFG_DO(cfg_do), .CFG_SHIFT(cfg_shift), .CFG_LATCH(cfg_latch),
    .FABRIC_RST(fabric_rst), .BUSY(busy), .DONE(done), .ERR(err),
    .STATE_DBG(state_dbg)
  );

  cfg_chain_loader #(.CHAIN_LEN(CL16), .SYNC_BYTE(8'hA5), .LATCH_CYCLES(LC16)) u_dut16 (
    .CLK(clk), .RST(rst), .START(start16), .host(bus16),
    .CFG_DO(cfg_do16), .CFG_SHIFT(cfg_shift16), .CFG_LATCH(cfg_latch16),
    .FABRIC_RST(fabric_rst16), .BUSY(busy16), .DONE(done16), .ERR(err16),
    .STATE_DBG(state_dbg16)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp16_q[$];
  int         span_q[$];
  bit         mon_en = 1'b0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: first len bits of the byte stream, LSB of each byte first.
  task automatic model_bits(input logic [7:0] data[$], input int len, input bit sel16);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = data[i / 8];
      if (sel16) exp16_q.push_back(b[i % 8]);
      else       exp_q.push_back(b[i % 8]);
    end
  endtask

  // ---------------- monitor, main instance ----------------
  bit         in_load    = 1'b0;
  bit         latch_prev = 1'b0;
  int         first_cyc, last_cyc;
  int         latch_run  = 0;
  logic [0:0] e_bit;

  always @(negedge clk) begin
    if (mon_en) begin
      check("latch_shift_overlap", cfg_latch & cfg_shift, 0);
      check("fabric_rst_vs_done", fabric_rst, !done);
      if (cfg_shift) begin
        if (exp_q.size() == 0) fail("unexpected_cfg_shift");
        else begin
          e_bit = exp_q.pop_front();
          check("cfg_do", cfg_do, e_bit);
        end
        if (!in_load) begin
          in_load   = 1'b1;
          first_cyc = cyc;
        end
        last_cyc = cyc;
      end
      if (cfg_latch && !latch_prev) begin
        if (span_q.size() == 0) fail("unexpected_cfg_latch");
        else begin
          check("shift_span", last_cyc - first_cyc + 1, span_q.pop_front());
          check("bits_remaining", exp_q.size(), 0);
        end
        in_load   = 1'b0;
        latch_run = 0;
      end
      if (cfg_latch) latch_run++;
      if (!cfg_latch && latch_prev) begin
        check("latch_len", latch_run, LC);
        check("done_after_latch", done, 1);
      end
      latch_prev = cfg_latch;
    end
    cyc++;
  end

  // ---------------- monitor, 16-bit instance ----------------
  int  n16 = 0;
  int  first16;
  bit  latch_prev16 = 1'b0;
  int  latch_run16  = 0;
  logic [0:0] e16;

  always @(negedge clk) begin
    if (mon_en) begin
      check("latch_shift_overlap16", cfg_latch16 & cfg_shift16, 0);
      if (cfg_shift16) begin
        if (exp16_q.size() == 0) fail("unexpected_cfg_shift16");
        else begin
          e16 = exp16_q.pop_front();
          check("cfg_do16", cfg_do16, e16);
        end
        n16++;
        if (n16 == 1) first16 = cyc;
        if (n16 == 8)  check("ready_on_last_bit_byte1", bus16.DIN_READY, 1);
        if (n16 == 16) begin
          check("ready_on_last_bit_byte2", bus16.DIN_READY, 1);
          check("contiguous16", cyc - first16 + 1, 16);
        end
      end
      if (cfg_latch16 && !latch_prev16) begin
        check("shift_count16", n16, CL16);
        latch_run16 = 0;
      end
      if (cfg_latch16) latch_run16++;
      if (!cfg_latch16 && latch_prev16) begin
        check("latch_len16", latch_run16, LC16);
        check("done16_after_latch", done16, 1);
      end
      latch_prev16 = cfg_latch16;
    end
  end

  // ---------------- driver tasks (run at posedge + #1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_din_ready"}, bus.DIN_READY, 0);
    check({tag, "_cfg_do"}, cfg_do, 0);
    check({tag, "_cfg_shift"}, cfg_shift, 0);
    check({tag, "_cfg_latch"}, cfg_latch, 0);
    check({tag, "_fabric_rst"}, fabric_rst, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic pulse_start(input bit chk);
    start = 1'b1;
    step();
    start = 1'b0;
    if (chk) begin
      check("start_busy", busy, 1);
      check("start_done_clr", done, 0);
      check("start_err_clr", err, 0);
      check("start_fabric_rst", fabric_rst, 1);
      check("start_sync_ready", bus.DIN_READY, 1);
    end
  endtask

  // gap > 0: keep VALID low for gap cycles after READY is first seen.
  task automatic drive_byte(input logic [7:0] b, input int gap);
    int t;
    bus.DIN_VALID = 1'b0;
    if (gap > 0) begin
      t = 0;
      while (!bus.DIN_READY && t < 100) begin step(); t++; end
      if (t >= 100) fail("ready_wait_timeout");
      repeat (gap) step();
    end
    bus.DIN       = b;
    bus.DIN_VALID = 1'b1;
    t = 0;
    while (!bus.DIN_READY && t < 100) begin step(); t++; end
    if (t >= 100) fail("accept_timeout");
    step();
    bus.DIN_VALID = 1'b0;
    bus.DIN       = 8'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 200) begin step(); t++; end
    if (t >= 200) fail("done_timeout");
    check("load_done", done, 1);
    check("load_fabric_rst", fabric_rst, 0);
    check("load_busy", busy, 0);
    check("load_err", err, 0);
  endtask

  task automatic do_load(input logic [7:0] d0, input logic [7:0] d1,
                         input int g0, input int g1, input bit noise);
    logic [7:0] q[$];
    int t;
    q = '{d0, d1};
    model_bits(q, CL, 1'b0);
    span_q.push_back(CL + g1);
    pulse_start(1'b1);
    drive_byte(8'hA5, 0);
    drive_byte(d0, g0);
    drive_byte(d1, g1);
    if (noise) begin
      pulse_start(1'b0);
      check("noise_busy_shift", busy, 1);
      t = 0;
      while (!cfg_latch && t < 40) begin step(); t++; end
      if (t >= 40) fail("latch_wait_timeout");
      pulse_start(1'b0);
    end
    wait_done();
  endtask

  task automatic bad_load(input logic [7:0] b);
    pulse_start(1'b1);
    drive_byte(b, 0);
    check("err_set", err, 1);
    check("err_busy", busy, 0);
    check("err_fabric_rst", fabric_rst, 1);
    check("err_ready", bus.DIN_READY, 0);
    check("err_done", done, 0);
    repeat (3) step();
    check("err_sticky", err, 1);
  endtask

  task automatic drive16(input logic [7:0] b);
    int t;
    bus16.DIN       = b;
    bus16.DIN_VALID = 1'b1;
    t = 0;
    while (!bus16.DIN_READY && t < 100) begin step(); t++; end
    if (t >= 100) fail("accept16_timeout");
    step();
    bus16.DIN_VALID = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [2:0] idle_code;
  logic [2:0] idle_code16;

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    start16         = 1'b0;
    bus.DIN         = 8'h00;
    bus.DIN_VALID   = 1'b0;
    bus16.DIN       = 8'h00;
    bus16.DIN_VALID = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_vals("reset");
    idle_code   = state_dbg;
    idle_code16 = state_dbg16;
    // VALID without START must be ignored in IDLE
    bus.DIN_VALID = 1'b1;
    bus.DIN       = 8'hA5;
    step();
    check("idle_ignores_valid", bus.DIN_READY, 0);
    check("idle_busy", busy, 0);
    bus.DIN_VALID = 1'b0;
    mon_en = 1'b1;

    // basic load A5,3C,0F
    do_load(8'h3C, 8'h0F, 0, 0, 1'b0);

    // bad sync, then restart from ERROR
    bad_load(8'h5A);
    do_load(8'h3C, 8'h0F, 0, 0, 1'b0);

    // VALID held low 5 cycles between data bytes
    do_load(8'h3C, 8'h0F, 0, 5, 1'b0);

    // START pulses during SHIFT and LATCH are ignored
    do_load(8'h3C, 8'h0F, 0, 0, 1'b1);

    // RST after 6 bits shifted
    begin
      logic [7:0] q[$];
      q = '{8'h3C, 8'h0F};
      model_bits(q, CL, 1'b0);
      span_q.push_back(CL);
      pulse_start(1'b1);
      drive_byte(8'hA5, 0);
      drive_byte(8'h3C, 0);
      repeat (5) step();
      rst = 1'b1;
      step();
      check_reset_vals("mid_rst");
      check("bits_before_rst", CL - exp_q.size(), 6);
      check("state_after_rst", state_dbg, idle_code);
      exp_q.delete();
      span_q.delete();
      in_load = 1'b0;
      rst = 1'b0;
      step();
      do_load(8'h3C, 8'h0F, 0, 0, 1'b0);
    end

    // randomized loads
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
        bad_load(b);
      end else begin
        do_load(8'($urandom), 8'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
    end

    // 16-bit chain, continuous A5,FF,00
    begin
      logic [7:0] q[$];
      int t;
      q = '{8'hFF, 8'h00};
      model_bits(q, CL16, 1'b1);
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      check("start16_busy", busy16, 1);
      drive16(8'hA5);
      drive16(8'hFF);
      drive16(8'h00);
      t = 0;
      while (!done16 && t < 200) begin step(); t++; end
      if (t >= 200) fail("done16_timeout");
      check("done16", done16, 1);
      check("fabric_rst16", fabric_rst16, 0);
      check("err16", err16, 0);
      check("bits_remaining16", exp16_q.size(), 0);
      check("state16_left_idle", state_dbg16 != idle_code16, 1);
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
